// File: rtl/dm_access_arbiter.sv
// Two-port arbiter in front of a single-port word-addressed data memory.
// Zero-fills the memory one word per cycle after reset, then grants accesses round-robin.
module dm_access_arbiter #(
    parameter int DEPTH          = 1024,
    parameter int AW             = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [31:0]   p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_gnt,
    output logic          p0_err,
    output logic [31:0]   p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [31:0]   p1_addr,
    input  logic [31:0]   p1_wdata,
    output logic          p1_gnt,
    output logic          p1_err,
    output logic [31:0]   p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam logic [AW:0] CLR_END = DEPTH[AW:0];

    state_t      state_r;
    logic [AW:0] clr_cnt_r;
    logic        rr_last_r;
    logic        acc_port_r;
    logic [1:0]  gnt_r;
    logic [1:0]  err_r;
    logic [1:0]  rd_en_r;

    logic        win_s;
    logic        req_any_s;
    logic        sel_we_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic        sel_legal_s;

    // Word aligned and inside the DEPTH-word window.
    function automatic logic addr_legal(input logic [31:0] addr);
        logic [31:0] hi;
        hi = addr >> (AW + 2);
        return (addr[1:0] == 2'b00) && (hi == 32'd0);
    endfunction

    assign req_any_s   = p0_req | p1_req;
    assign sel_legal_s = addr_legal(sel_addr_s);

    // Winner selection: a lone requester wins, a tie goes to the port that did not win last.
    always_comb begin
        win_s       = 1'b0;
        sel_we_s    = 1'b0;
        sel_addr_s  = 32'd0;
        sel_wdata_s = 32'd0;
        if (p0_req && p1_req) begin
            win_s = ~rr_last_r;
        end else if (p1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (win_s) begin
            sel_we_s    = p1_we;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else begin
            sel_we_s    = p0_we;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end
    end

    // Sequencer: clear walk, arbitration and the one-cycle access, all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_cnt_r  <= '0;
            rr_last_r  <= 1'b1;
            acc_port_r <= 1'b0;
            gnt_r      <= 2'b00;
            err_r      <= 2'b00;
            rd_en_r    <= 2'b00;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            mem_we     <= 1'b0;
            busy       <= CLEAR_ON_RESET;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    // Counter runs one past the last word so the final write cycle is not cut short.
                    if (clr_cnt_r == CLR_END) begin
                        state_r  <= ST_IDLE;
                        mem_we   <= 1'b0;
                        mem_addr <= '0;
                        busy     <= 1'b0;
                    end else begin
                        mem_we    <= 1'b1;
                        mem_addr  <= clr_cnt_r[AW-1:0];
                        mem_wdata <= 32'd0;
                        clr_cnt_r <= clr_cnt_r + {{AW{1'b0}}, 1'b1};
                        busy      <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_any_s) begin
                        state_r    <= ST_ACCESS;
                        acc_port_r <= win_s;
                        gnt_r      <= win_s ? 2'b10 : 2'b01;
                        err_r      <= win_s ? {~sel_legal_s, 1'b0} : {1'b0, ~sel_legal_s};
                        rd_en_r    <= win_s ? {~sel_we_s & sel_legal_s, 1'b0}
                                            : {1'b0, ~sel_we_s & sel_legal_s};
                        mem_addr   <= sel_addr_s[AW+1:2];
                        mem_we     <= sel_we_s & sel_legal_s;
                        mem_wdata  <= (sel_we_s & sel_legal_s) ? sel_wdata_s : 32'd0;
                    end else begin
                        state_r <= ST_IDLE;
                        gnt_r   <= 2'b00;
                        err_r   <= 2'b00;
                        rd_en_r <= 2'b00;
                        mem_we  <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    state_r   <= ST_IDLE;
                    rr_last_r <= acc_port_r;
                    gnt_r     <= 2'b00;
                    err_r     <= 2'b00;
                    rd_en_r   <= 2'b00;
                    mem_we    <= 1'b0;
                    mem_wdata <= 32'd0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= 2'b00;
                    err_r   <= 2'b00;
                    rd_en_r <= 2'b00;
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign p0_gnt   = gnt_r[0];
    assign p1_gnt   = gnt_r[1];
    assign p0_err   = err_r[0];
    assign p1_err   = err_r[1];
    assign p0_rdata = rd_en_r[0] ? mem_rdata : 32'd0;
    assign p1_rdata = rd_en_r[1] ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Bench for dm_access_arbiter: behavioural memory array, reference memory model
// and a queue of expected grants compared as each grant appears.
module tb_dm_access_arbiter;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    typedef struct {
        logic          port;
        logic          err;
        logic [31:0]   rdata;
        logic          we;
        logic [AW-1:0] addr;
    } exp_t;

    typedef struct {
        bit            got;
        int            cyc;
        logic          port;
        logic          err;
        logic [31:0]   rdata;
        logic          we;
        logic [AW-1:0] addr;
        logic          loser;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_req, p0_we, p0_gnt, p0_err;
    logic [31:0]   p0_addr, p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_gnt, p1_err;
    logic [31:0]   p1_addr, p1_wdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_we, busy;

    logic [31:0] mem   [DEPTH];
    logic [31:0] model [DEPTH];
    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;

    dm_access_arbiter #(.DEPTH(DEPTH), .AW(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    endtask

    task automatic issue(input logic port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        logic        legal;
        logic [31:0] hi;
        hi      = addr >> (AW + 2);
        legal   = (addr[1:0] == 2'b00) && (hi == 32'd0);
        e.port  = port;
        e.err   = !legal;
        e.we    = we && legal;
        e.addr  = addr[AW+1:2];
        e.rdata = (!we && legal) ? model[addr[AW+1:2]] : 32'd0;
        if (we && legal) model[addr[AW+1:2]] = wdata;
        sb_q.push_back(e);
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic pop_exp(output exp_t e);
        e = '{port: 1'b0, err: 1'b0, rdata: 32'hFFFF_FFFF, we: 1'b0, addr: '0};
        if (sb_q.size() > 0) e = sb_q.pop_front();
    endtask

    task automatic wait_grant(input int max_cyc, output obs_t o);
        o = '{got: 1'b0, cyc: 0, port: 1'b0, err: 1'b0, rdata: 32'd0, we: 1'b0, addr: '0, loser: 1'b0};
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            o.cyc++;
            if (p0_gnt || p1_gnt) begin
                o.got   = 1'b1;
                o.port  = p1_gnt;
                o.err   = p1_gnt ? p1_err : p0_err;
                o.rdata = p1_gnt ? p1_rdata : p0_rdata;
                o.we    = mem_we;
                o.addr  = mem_addr;
                o.loser = p1_gnt ? (p0_gnt | p0_err | (|p0_rdata)) : (p1_gnt | p1_err | (|p1_rdata));
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        int first_bad = -1;
        int nz = 0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, mem_we, p0_gnt, p1_gnt, p0_err, p1_err} !== 6'b100000 || mem_addr !== '0
            || p0_rdata !== 32'd0 || p1_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_state busy=%b we=%b gnt=%b%b err=%b%b addr=%0d required busy=1 others 0",
                     busy, mem_we, p1_gnt, p0_gnt, p1_err, p0_err, mem_addr);
        end
        reset = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(k) || mem_wdata !== 32'd0) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL clear_walk bad_cycles=%0d first_at=%0d required 0 bad cycles", bad, first_bad);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL clear_end busy=%b we=%b required 0 0", busy, mem_we);
        end
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== 32'd0) nz++;
        checks++;
        if (nz !== 0) begin
            failures++;
            $display("FAIL clear_zero nonzero_words=%0d required 0", nz);
        end
        model_clear();
    endtask

    task automatic test_round_robin();
        obs_t o;
        exp_t e;
        issue(1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_0001);
        issue(1'b1, 1'b0, 32'h0000_0020, 32'd0);
        issue(1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_0001);
        issue(1'b1, 1'b0, 32'h0000_0020, 32'd0);
        for (int n = 0; n < 4; n++) begin
            wait_grant(8, o);
            pop_exp(e);
            checks++;
            if (!o.got || o.port !== e.port || o.err !== e.err || o.rdata !== e.rdata || o.we !== e.we
                || o.loser !== 1'b0 || o.cyc !== ((n == 0) ? 1 : 2)) begin
                failures++;
                $display("FAIL rr_grant%0d got=%0b port=%0b err=%0b rdata=%h we=%0b loser=%0b cyc=%0d required port=%0b err=%0b rdata=%h we=%0b loser=0 cyc=%0d",
                         n, o.got, o.port, o.err, o.rdata, o.we, o.loser, o.cyc, e.port, e.err, e.rdata, e.we, (n == 0) ? 1 : 2);
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    task automatic test_write_read();
        obs_t o;
        exp_t e;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            issue(1'b0, (n == 0), 32'h0000_0010, 32'h1234_5678);
            wait_grant(8, o);
            p0_req = 1'b0;
            pop_exp(e);
            checks++;
            if (!o.got || o.cyc !== 1 || o.port !== 1'b0 || o.err !== 1'b0 || o.rdata !== e.rdata
                || o.we !== e.we || o.addr !== AW'(4) || o.loser !== 1'b0) begin
                failures++;
                $display("FAIL p0_%s got=%0b cyc=%0d port=%0b err=%0b rdata=%h we=%0b addr=%0d required cyc=1 port=0 err=0 rdata=%h we=%0b addr=4",
                         (n == 0) ? "write" : "read", o.got, o.cyc, o.port, o.err, o.rdata, o.we, o.addr, e.rdata, e.we);
            end
        end
    endtask

    task automatic test_illegal();
        obs_t        o;
        exp_t        e;
        logic        t_port [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        t_we   [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] t_addr [7] = '{32'h0000_0FFC, 32'h0000_0006, 32'h0000_1000, 32'h0000_0FFC,
                                    32'h0000_0004, 32'h0000_0000, 32'h8000_0010};
        logic [31:0] t_data [7] = '{32'hCAFE_F00D, 32'hDEAD_BEEF, 32'hBEEF_CAFE, 32'd0,
                                    32'd0, 32'd0, 32'd0};
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            issue(t_port[n], t_we[n], t_addr[n], t_data[n]);
            wait_grant(8, o);
            p0_req = 1'b0;
            p1_req = 1'b0;
            pop_exp(e);
            checks++;
            if (!o.got || o.port !== e.port || o.err !== e.err || o.rdata !== e.rdata || o.we !== e.we
                || (!e.err && o.addr !== e.addr) || o.loser !== 1'b0) begin
                failures++;
                $display("FAIL access_%0d addr=%h got=%0b port=%0b err=%0b rdata=%h we=%0b maddr=%0d required port=%0b err=%0b rdata=%h we=%0b maddr=%0d",
                         n, t_addr[n], o.got, o.port, o.err, o.rdata, o.we, o.addr, e.port, e.err, e.rdata, e.we, e.addr);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        obs_t o;
        exp_t e;
        @(negedge clk);
        issue(1'b0, 1'b1, 32'h0000_0040, 32'h1111_1111);
        wait_grant(8, o);
        p0_req = 1'b0;
        pop_exp(e);
        @(negedge clk);
        issue(1'b0, 1'b1, 32'h0000_0040, 32'h2222_2222);
        wait_grant(8, o);
        pop_exp(e);
        checks++;
        if (!o.got || o.we !== 1'b1 || o.port !== 1'b0) begin
            failures++;
            $display("FAIL abort_setup got=%0b we=%0b port=%0b required got=1 we=1 port=0", o.got, o.we, o.port);
        end
        reset  = 1'b0;
        p0_req = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || p0_gnt !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL async_reset we=%b gnt=%b busy=%b required 0 0 1", mem_we, p0_gnt, busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (mem[16] !== 32'h1111_1111) begin
            failures++;
            $display("FAIL aborted_write mem[16]=%h required 11111111", mem[16]);
        end
        model_clear();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_addr !== '0 || mem_we !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL clear_restart addr=%0d we=%b busy=%b required 0 1 1", mem_addr, mem_we, busy);
        end
    endtask

    task automatic test_req_during_clear();
        obs_t o;
        exp_t e;
        int   busy_cyc = 0;
        int   early = 0;
        int   nz = 0;
        issue(1'b0, 1'b1, 32'h0000_0300, 32'h0BAD_F00D);
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (p0_gnt || p1_gnt) early++;
            if (busy !== 1'b1) break;
            busy_cyc++;
        end
        checks++;
        if (busy_cyc !== DEPTH - 1 || early !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_hold busy_cycles=%0d early_gnts=%0d busy=%b required %0d 0 0",
                     busy_cyc, early, busy, DEPTH - 1);
        end
        wait_grant(8, o);
        p0_req = 1'b0;
        pop_exp(e);
        checks++;
        if (!o.got || o.cyc !== 1 || o.port !== 1'b0 || o.err !== 1'b0 || o.we !== 1'b1 || o.addr !== e.addr) begin
            failures++;
            $display("FAIL post_clear_gnt got=%0b cyc=%0d port=%0b err=%0b we=%0b addr=%0d required cyc=1 port=0 err=0 we=1 addr=%0d",
                     o.got, o.cyc, o.port, o.err, o.we, o.addr, e.addr);
        end
        @(negedge clk);
        issue(1'b0, 1'b0, 32'h0000_0300, 32'd0);
        wait_grant(8, o);
        p0_req = 1'b0;
        pop_exp(e);
        checks++;
        if (!o.got || o.rdata !== e.rdata || o.err !== 1'b0) begin
            failures++;
            $display("FAIL post_clear_read got=%0b rdata=%h err=%0b required rdata=%h err=0", o.got, o.rdata, o.err, e.rdata);
        end
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== model[i]) nz++;
        checks++;
        if (nz !== 0) begin
            failures++;
            $display("FAIL memory_image differing_words=%0d required 0", nz);
        end
    endtask

    initial begin
        reset  = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'd0; p0_wdata = 32'd0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'd0; p1_wdata = 32'd0;
        test_reset();
        test_round_robin();
        test_write_read();
        test_illegal();
        test_reset_mid_access();
        test_req_during_clear();
        checks++;
        if (sb_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
